// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the MIPS memory stage:
//   - mem_size_e  : encodings of the MemSize control field
//   - mem_state_e : states of the data-memory access FSM
//   - DEFAULT_TIMEOUT : default number of wait cycles before a bus error
//   - is_byte_size() : true for the two byte-wide access encodings
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    MS_WORD  = 2'b00,
    MS_BYTEU = 2'b01,
    MS_BYTES = 2'b10,
    MS_RSVD  = 2'b11   // reserved, behaves as a word access
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_ERR    = 2'b10
  } mem_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

  // Byte accesses are the only sub-word accesses; everything else
  // (including the reserved code) is handled as a full word.
  function automatic logic is_byte_size(input logic [1:0] size);
    logic result;
    case (size)
      MS_BYTEU, MS_BYTES: result = 1'b1;
      default:            result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pipeline_mem_stage_if.sv
// -----------------------------------------------------------------------------
// pipeline_mem_stage_if
// Request/acknowledge data-memory port of the memory stage.
//   dmem_req   : access request, held until dmem_ack
//   dmem_we    : write strobe (store)
//   dmem_addr  : word-aligned address
//   dmem_wdata : store data (byte stores replicated on every lane)
//   dmem_be    : byte enables
//   dmem_rdata : load data, valid together with dmem_ack
//   dmem_ack   : access complete
// Modports: master (pipeline side), slave (memory side).
// -----------------------------------------------------------------------------
interface pipeline_mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Purely combinational lane handling for the memory stage.
//   lane       in  2   byte lane = address[1:0]
//   size       in  2   MemSize encoding (see pipeline_pkg::mem_size_e)
//   store_data in  32  store data from the EX/MEM latch
//   rdata      in  32  raw word returned by memory
//   be         out 4   byte enables (one-hot for bytes, all ones for words)
//   wdata      out 32  store data, low byte replicated for byte stores
//   load_data  out 32  selected lane, zero/sign extended for byte loads
// -----------------------------------------------------------------------------
module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] lane_byte_s;

  // Select the addressed byte out of the returned word.
  always_comb begin
    lane_byte_s = 8'h00;
    case (lane)
      2'd0:    lane_byte_s = rdata[7:0];
      2'd1:    lane_byte_s = rdata[15:8];
      2'd2:    lane_byte_s = rdata[23:16];
      2'd3:    lane_byte_s = rdata[31:24];
      default: lane_byte_s = rdata[7:0];
    endcase
  end

  // Extend the selected byte, or pass the word through untouched.
  always_comb begin
    load_data = rdata;
    case (size)
      MS_BYTEU: load_data = {24'h000000, lane_byte_s};
      MS_BYTES: load_data = {{24{lane_byte_s[7]}}, lane_byte_s};
      default:  load_data = rdata;
    endcase
  end

  // Byte enables and store data; a byte store drives the same byte on
  // all lanes so memory only has to honour the enables.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_byte_size(size)) begin
      be    = 4'b0001 << lane;
      wdata = {4{store_data[7:0]}};
    end else begin
      be    = 4'b1111;
      wdata = store_data;
    end
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// -----------------------------------------------------------------------------
// pipeline_mem_stage
// Memory stage of the five-stage MIPS pipeline: EX/MEM latch, data-memory
// access FSM with timeout, MEM/WB latch and forwarding sources.
//
// Parameters:
//   TIMEOUT  wait cycles without dmem_ack before the access is abandoned
//            with a bus error (default pipeline_pkg::DEFAULT_TIMEOUT).
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   EX_valid .. EX_rd        execute-stage results and control
//   EXMEMdata/_rd/_RegWrite  EX/MEM latch, forwarding + hazard detection
//   MEM_stall                freezes PC, IF/ID, ID/EX (combinational)
//   dmem                     req/ack data-memory port (master modport)
//   MEMWBdata/_rd/_RegWrite  MEM/WB latch, write-back + forwarding
//   MEM_buserr               one-cycle pulse when an access times out
//   MEM_misalign             only with MEM_ALIGN_CHECK_EN: one-cycle pulse
//                            for a misaligned word access (no request issued)
//
// Build option: define MEM_ALIGN_CHECK_EN to enable word-alignment checking.
// -----------------------------------------------------------------------------
module pipeline_mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [31:0] EX_ALUOut,
  input  logic [31:0] EX_rt_postForward,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemSize,
  input  logic        EX_MemToReg,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_rd,
  output logic [31:0] EXMEMdata,
  output logic [4:0]  EXMEM_rd,
  output logic        EXMEM_RegWrite,
  output logic        MEM_stall,
  pipeline_mem_stage_if.master dmem,
  output logic [31:0] MEMWBdata,
  output logic [4:0]  MEMWB_rd,
  output logic        MEMWB_RegWrite,
  output logic        MEM_buserr
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        MEM_misalign
`endif
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // EX/MEM latch
  logic [31:0] exmem_alu_r;
  logic [31:0] exmem_wdata_r;
  logic        exmem_memread_r;
  logic        exmem_memwrite_r;
  logic [1:0]  exmem_size_r;
  logic        exmem_memtoreg_r;
  logic        exmem_regwrite_r;
  logic [4:0]  exmem_rd_r;

  // Access FSM
  mem_state_e  state_r;
  mem_state_e  state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [CW-1:0] cnt_inc_s;

  // MEM/WB latch
  logic [31:0] memwb_data_r;
  logic [4:0]  memwb_rd_r;
  logic        memwb_regwrite_r;

  logic        access_s;
  logic        incoming_mem_s;
  logic        in_misalign_s;
  logic        ex_misalign_s;
  logic        wb_load_s;
  logic        wb_squash_s;
  logic        wb_we_s;
  logic [31:0] wb_data_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] load_data_s;

  assign access_s  = (state_r == S_ACCESS);
  assign MEM_stall = access_s && !dmem.dmem_ack;

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned word access never reaches the bus; it is recognised both
  // as it enters the latch (to keep the FSM idle) and while it sits there
  // (to pulse MEM_misalign and squash the write-back).
  assign in_misalign_s = (EX_MemRead || EX_MemWrite) && !is_byte_size(EX_MemSize)
                         && (EX_ALUOut[1:0] != 2'b00);
  assign ex_misalign_s = (exmem_memread_r || exmem_memwrite_r) && !is_byte_size(exmem_size_r)
                         && (exmem_alu_r[1:0] != 2'b00);
  assign MEM_misalign  = (state_r == S_IDLE) && ex_misalign_s;
`else
  assign in_misalign_s = 1'b0;
  assign ex_misalign_s = 1'b0;
`endif

  // The FSM enters ACCESS on the same edge that latches a memory op, so
  // the request goes out in the instruction's first MEM cycle.
  assign incoming_mem_s = EX_valid && (EX_MemRead || EX_MemWrite) && !in_misalign_s;

  mem_load_align u_align (
    .lane       (exmem_alu_r[1:0]),
    .size       (exmem_size_r),
    .store_data (exmem_wdata_r),
    .rdata      (dmem.dmem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  // Bus outputs are only meaningful during ACCESS; elsewhere they rest at 0.
  assign dmem.dmem_req   = access_s;
  assign dmem.dmem_we    = access_s && exmem_memwrite_r;
  assign dmem.dmem_addr  = access_s ? {exmem_alu_r[31:2], 2'b00} : 32'h0000_0000;
  assign dmem.dmem_be    = access_s ? be_s : 4'b0000;
  assign dmem.dmem_wdata = access_s ? wdata_s : 32'h0000_0000;

  // EX/MEM latch: frozen while stalled; an invalid slot becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_alu_r      <= 32'h0000_0000;
      exmem_wdata_r    <= 32'h0000_0000;
      exmem_memread_r  <= 1'b0;
      exmem_memwrite_r <= 1'b0;
      exmem_size_r     <= 2'b00;
      exmem_memtoreg_r <= 1'b0;
      exmem_regwrite_r <= 1'b0;
      exmem_rd_r       <= 5'd0;
    end else if (!MEM_stall) begin
      exmem_alu_r      <= EX_ALUOut;
      exmem_wdata_r    <= EX_rt_postForward;
      exmem_memread_r  <= EX_valid && EX_MemRead;
      exmem_memwrite_r <= EX_valid && EX_MemWrite;
      exmem_size_r     <= EX_MemSize;
      exmem_memtoreg_r <= EX_MemToReg;
      exmem_regwrite_r <= EX_valid && EX_RegWrite;
      exmem_rd_r       <= EX_rd;
    end
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic. The timeout fires on the edge where the counter
  // would reach TIMEOUT; an ack in that same cycle is checked first and wins.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cnt_inc_s    = (cnt_r == TMO) ? cnt_r : (cnt_r + CNT_ONE);
    case (state_r)
      S_IDLE, S_ERR: begin
        cnt_next_s = '0;
        if (incoming_mem_s) begin
          state_next_s = S_ACCESS;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (dmem.dmem_ack) begin
          // Back-to-back memory ops go straight into a fresh access.
          cnt_next_s = '0;
          if (incoming_mem_s) begin
            state_next_s = S_ACCESS;
          end else begin
            state_next_s = S_IDLE;
          end
        end else if (cnt_inc_s == TMO) begin
          cnt_next_s   = cnt_inc_s;
          state_next_s = S_ERR;
        end else begin
          cnt_next_s   = cnt_inc_s;
          state_next_s = S_ACCESS;
        end
      end
      default: begin
        cnt_next_s   = '0;
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Decide when the stage completes and whether its write-back survives.
  always_comb begin
    wb_load_s   = 1'b0;
    wb_squash_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        wb_load_s   = 1'b1;
        wb_squash_s = ex_misalign_s;
      end
      S_ACCESS: begin
        wb_load_s   = dmem.dmem_ack;
        wb_squash_s = 1'b0;
      end
      S_ERR: begin
        wb_load_s   = 1'b1;
        wb_squash_s = 1'b1;
      end
      default: begin
        wb_load_s   = 1'b1;
        wb_squash_s = 1'b1;
      end
    endcase
    wb_we_s   = wb_load_s && !wb_squash_s && exmem_regwrite_r;
    wb_data_s = exmem_memtoreg_r ? load_data_s : exmem_alu_r;
  end

  // MEM/WB latch: RegWrite is re-evaluated every cycle so a stalled access
  // presents a bubble and can never write back twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_data_r     <= 32'h0000_0000;
      memwb_rd_r       <= 5'd0;
      memwb_regwrite_r <= 1'b0;
    end else begin
      memwb_regwrite_r <= wb_we_s;
      if (wb_load_s) begin
        memwb_data_r <= wb_data_s;
        memwb_rd_r   <= exmem_rd_r;
      end
    end
  end

  assign EXMEMdata      = exmem_alu_r;
  assign EXMEM_rd       = exmem_rd_r;
  assign EXMEM_RegWrite = exmem_regwrite_r;
  assign MEMWBdata      = memwb_data_r;
  assign MEMWB_rd       = memwb_rd_r;
  assign MEMWB_RegWrite = memwb_regwrite_r;
  assign MEM_buserr     = (state_r == S_ERR);

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_pipeline_mem_stage
// Directed bench for pipeline_mem_stage (TIMEOUT = 15). Expected write-backs
// are queued when an instruction is issued and compared when MEM/WB fires.
// -----------------------------------------------------------------------------
module tb_pipeline_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_valid;
  logic [31:0] EX_ALUOut;
  logic [31:0] EX_rt_postForward;
  logic        EX_MemRead;
  logic        EX_MemWrite;
  logic [1:0]  EX_MemSize;
  logic        EX_MemToReg;
  logic        EX_RegWrite;
  logic [4:0]  EX_rd;
  logic [31:0] EXMEMdata;
  logic [4:0]  EXMEM_rd;
  logic        EXMEM_RegWrite;
  logic        MEM_stall;
  logic [31:0] MEMWBdata;
  logic [4:0]  MEMWB_rd;
  logic        MEMWB_RegWrite;
  logic        MEM_buserr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        MEM_misalign;
`endif

  pipeline_mem_stage_if dmem_bus ();

  always #5 clk = ~clk;

  pipeline_mem_stage #(.TIMEOUT(15)) dut (
    .clk               (clk),
    .reset             (reset),
    .EX_valid          (EX_valid),
    .EX_ALUOut         (EX_ALUOut),
    .EX_rt_postForward (EX_rt_postForward),
    .EX_MemRead        (EX_MemRead),
    .EX_MemWrite       (EX_MemWrite),
    .EX_MemSize        (EX_MemSize),
    .EX_MemToReg       (EX_MemToReg),
    .EX_RegWrite       (EX_RegWrite),
    .EX_rd             (EX_rd),
    .EXMEMdata         (EXMEMdata),
    .EXMEM_rd          (EXMEM_rd),
    .EXMEM_RegWrite    (EXMEM_RegWrite),
    .MEM_stall         (MEM_stall),
    .dmem              (dmem_bus),
    .MEMWBdata         (MEMWBdata),
    .MEMWB_rd          (MEMWB_rd),
    .MEMWB_RegWrite    (MEMWB_RegWrite),
    .MEM_buserr        (MEM_buserr)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .MEM_misalign      (MEM_misalign)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];   // {rd, data} of each expected write-back

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock, then score any write-back against the queue.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk1("spurious_wb", MEMWB_RegWrite, 1'b0);
    end else if (MEMWB_RegWrite) begin
      e = exp_q.pop_front();
      chk("wb_rd", 32'(MEMWB_rd), 32'(e[36:32]));
      chk("wb_data", MEMWBdata, e[31:0]);
    end
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic [1:0] sz,
                        input logic m2r, input logic rw);
    EX_valid          = 1'b1;
    EX_ALUOut         = alu;
    EX_rt_postForward = st;
    EX_rd             = rd;
    EX_MemRead        = mr;
    EX_MemWrite       = mw;
    EX_MemSize        = sz;
    EX_MemToReg       = m2r;
    EX_RegWrite       = rw;
  endtask

  task automatic idle_ex();
    EX_valid          = 1'b0;
    EX_ALUOut         = 32'h0000_0000;
    EX_rt_postForward = 32'h0000_0000;
    EX_rd             = 5'd0;
    EX_MemRead        = 1'b0;
    EX_MemWrite       = 1'b0;
    EX_MemSize        = 2'b00;
    EX_MemToReg       = 1'b0;
    EX_RegWrite       = 1'b1;   // must be ignored when EX_valid is low
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    int guard;

    reset = 1'b1;
    idle_ex();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0000_0000;
    tick();
    tick();
    // Reset state
    chk("rst_exmemdata", EXMEMdata, 32'h0);
    chk1("rst_exmem_rw", EXMEM_RegWrite, 1'b0);
    chk1("rst_stall", MEM_stall, 1'b0);
    chk1("rst_req", dmem_bus.dmem_req, 1'b0);
    chk("rst_be", 32'(dmem_bus.dmem_be), 32'h0);
    chk("rst_memwbdata", MEMWBdata, 32'h0);
    chk1("rst_buserr", MEM_buserr, 1'b0);
    reset = 1'b0;

    // ALU op: one cycle to EX/MEM, one more to MEM/WB
    set_ex(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    exp_q.push_back({5'd5, 32'h0000_1234});
    tick();
    chk("alu_exmemdata", EXMEMdata, 32'h0000_1234);
    chk("alu_exmem_rd", 32'(EXMEM_rd), 32'd5);
    chk1("alu_exmem_rw", EXMEM_RegWrite, 1'b1);
    chk1("alu_stall", MEM_stall, 1'b0);
    idle_ex();
    tick();
    chk1("bubble_exmem_rw", EXMEM_RegWrite, 1'b0);
    chk("alu_q_empty", 32'(exp_q.size()), 32'd0);

    // Word store, ack after three wait cycles
    set_ex(32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk1("st_stall", MEM_stall, 1'b1);
      chk1("st_req", dmem_bus.dmem_req, 1'b1);
      chk1("st_we", dmem_bus.dmem_we, 1'b1);
      chk("st_addr", dmem_bus.dmem_addr, 32'h0000_0100);
      chk("st_be", 32'(dmem_bus.dmem_be), 32'h0000_000F);
      chk("st_wdata", dmem_bus.dmem_wdata, 32'hDEAD_BEEF);
      tick();
    end
    dmem_bus.dmem_ack = 1'b1;
    idle_ex();
    #1;
    chk1("st_ack_stall", MEM_stall, 1'b0);
    chk("st_ack_wdata", dmem_bus.dmem_wdata, 32'hDEAD_BEEF);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk1("st_memwb_rw", MEMWB_RegWrite, 1'b0);
    chk1("st_done_req", dmem_bus.dmem_req, 1'b0);

    // Signed byte load from 0x103, zero-wait ack
    set_ex(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    exp_q.push_back({5'd7, 32'hFFFF_FF80});
    tick();
    dmem_bus.dmem_rdata = 32'h8000_0000;
    dmem_bus.dmem_ack   = 1'b1;
    #1;
    chk1("lbs_stall", MEM_stall, 1'b0);
    chk("lbs_addr", dmem_bus.dmem_addr, 32'h0000_0100);
    chk("lbs_be", 32'(dmem_bus.dmem_be), 32'h0000_0008);
    chk1("lbs_we", dmem_bus.dmem_we, 1'b0);
    // Unsigned byte load from the same address, back to back
    set_ex(32'h0000_0103, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    exp_q.push_back({5'd8, 32'h0000_0080});
    tick();
    chk1("lbu_req", dmem_bus.dmem_req, 1'b1);
    chk1("lbu_stall", MEM_stall, 1'b0);
    // Byte store 0xA5 to 0x302
    set_ex(32'h0000_0302, 32'h1234_56A5, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    chk("sb_be", 32'(dmem_bus.dmem_be), 32'h0000_0004);
    chk("sb_wdata", dmem_bus.dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", dmem_bus.dmem_addr, 32'h0000_0300);
    chk1("sb_we", dmem_bus.dmem_we, 1'b1);
    // Signed byte load, lane 1, positive value
    set_ex(32'h0000_0201, 32'h0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    exp_q.push_back({5'd12, 32'h0000_007F});
    tick();
    dmem_bus.dmem_rdata = 32'h0000_7F00;
    #1;
    chk("lb1_be", 32'(dmem_bus.dmem_be), 32'h0000_0002);
    idle_ex();
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk("loads_q_empty", 32'(exp_q.size()), 32'd0);

    // Ack never arrives: 15 stall cycles, then a one-cycle bus error
    set_ex(32'h0000_0400, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    stalls = 0;
    guard  = 0;
    while (!MEM_buserr && guard < 40) begin
      if (MEM_stall) stalls++;
      tick();
      guard++;
    end
    chk1("to_buserr_seen", MEM_buserr, 1'b1);
    chk("to_stall_cycles", 32'(stalls), 32'd15);
    chk1("to_err_stall", MEM_stall, 1'b0);
    chk1("to_err_req", dmem_bus.dmem_req, 1'b0);
    idle_ex();
    tick();
    chk1("to_buserr_pulse", MEM_buserr, 1'b0);
    chk1("to_memwb_rw", MEMWB_RegWrite, 1'b0);

    // Ack in the 15th wait cycle beats the timeout
    set_ex(32'h0000_0500, 32'h0, 5'd10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    exp_q.push_back({5'd10, 32'hCAFE_F00D});
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk1("race_stall_before", MEM_stall, 1'b1);
    dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    dmem_bus.dmem_ack   = 1'b1;
    #1;
    chk1("race_stall", MEM_stall, 1'b0);
    idle_ex();
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk1("race_no_buserr", MEM_buserr, 1'b0);
    chk("race_q_empty", 32'(exp_q.size()), 32'd0);

    // Spurious ack while idle is ignored
    dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
    dmem_bus.dmem_ack   = 1'b1;
    #1;
    chk1("spur_stall", MEM_stall, 1'b0);
    chk1("spur_req", dmem_bus.dmem_req, 1'b0);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk1("spur_req_after", dmem_bus.dmem_req, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load: no request, one-cycle flag, squashed
    set_ex(32'h0000_0102, 32'h0, 5'd13, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    chk1("mis_flag", MEM_misalign, 1'b1);
    chk1("mis_req", dmem_bus.dmem_req, 1'b0);
    chk1("mis_stall", MEM_stall, 1'b0);
    idle_ex();
    tick();
    chk1("mis_flag_pulse", MEM_misalign, 1'b0);
    chk1("mis_memwb_rw", MEMWB_RegWrite, 1'b0);
`endif

    // Reset on the second wait cycle of a load
    set_ex(32'h0000_0600, 32'h0, 5'd11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    chk1("rmid_wait1", MEM_stall, 1'b1);
    tick();
    chk1("rmid_wait2", MEM_stall, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rmid_req", dmem_bus.dmem_req, 1'b0);
    chk1("rmid_stall", MEM_stall, 1'b0);
    chk("rmid_exmemdata", EXMEMdata, 32'h0);
    chk1("rmid_exmem_rw", EXMEM_RegWrite, 1'b0);
    chk("rmid_memwbdata", MEMWBdata, 32'h0);
    chk("rmid_memwb_rd", 32'(MEMWB_rd), 32'd0);
    idle_ex();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("rmid_no_replay", dmem_bus.dmem_req, 1'b0);
    end

    // Pipeline still works after the reset
    set_ex(32'h0000_55AA, 32'h0, 5'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    exp_q.push_back({5'd3, 32'h0000_55AA});
    tick();
    chk("post_exmemdata", EXMEMdata, 32'h0000_55AA);
    idle_ex();
    tick();
    tick();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_stage.md
# pipeline_mem_stage

Memory stage of the five-stage MIPS pipeline. It sits directly downstream of the execute stage. It registers the ALU result, forwarded store data and control into the EX/MEM latch, and drives a req/ack data-memory port. It stalls upstream stages until the access completes, then fills the MEM/WB latch. It also supplies `EXMEMdata` and `MEMWBdata` to the execute-stage forwarding muxes.

## Interface
Parameters:
- `TIMEOUT` — default 15 — maximum cycles waiting for `dmem_ack` before a bus error.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `EX_valid`  in  1  the execute-stage slot holds a real instruction.
- `EX_ALUOut`  in  32  ALU result; serves as the memory address for loads and stores.
- `EX_rt_postForward`  in  32  store data, already forwarded.
- `EX_MemRead`, `EX_MemWrite`  in  1  load / store.
- `EX_MemSize`  in  2  00 word, 01 byte unsigned, 10 byte signed, 11 reserved (treated as word).
- `EX_MemToReg`, `EX_RegWrite`  in  1  write-back select / register write enable.
- `EX_rd`  in  5  destination register.
- `EXMEMdata`  out  32  registered ALU result (forwarding source, ForwardA/B = 2'b10).
- `EXMEM_rd`, `EXMEM_RegWrite`  out  5/1  hazard-detection inputs.
- `MEM_stall`  out  1  freezes PC, IF/ID and ID/EX, and holds `EX_*` stable.
- `dmem_req`, `dmem_we`  out  1  request / write strobe.
- `dmem_addr`  out  32  word address, bits [1:0] forced to 0.
- `dmem_wdata`  out  32  store data, replicated per lane for byte stores.
- `dmem_be`  out  4  byte enables.
- `dmem_rdata`  in  32  load data, valid with `dmem_ack`.
- `dmem_ack`  in  1  access complete.
- `MEMWBdata`  out  32  final write-back value (forwarding source, ForwardA/B = 2'b01).
- `MEMWB_rd`, `MEMWB_RegWrite`  out  5/1  write-back target.
- `MEM_buserr`  out  1  one-cycle pulse when an access times out.

## Operation
- EX/MEM latch loads `EX_*` on each rising edge while `MEM_stall`=0. If `EX_valid`=0, it loads a bubble: RegWrite, MemRead and MemWrite all 0.
- FSM states:
  - IDLE → ACCESS when the latched instruction has MemRead or MemWrite set.
  - ACCESS: `dmem_req`=1, `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` held stable. On `dmem_ack` → IDLE. On the wait counter reaching `TIMEOUT` → ERR.
  - ERR: pulse `MEM_buserr`, squash the instruction (MEMWB_RegWrite=0) → IDLE.
- `MEM_stall` = (state==ACCESS && !dmem_ack) — combinational, so a zero-wait ack costs no stall.
- Wait counter: cleared on entry to ACCESS, increments each cycle without ack, saturates at `TIMEOUT`.
- Byte lane = addr[1:0]; `dmem_be` = 4'b0001 << lane; word access gives 4'b1111.
- Load data is extracted from `rdata[8*lane+7:8*lane]`, zero- or sign-extended per `MemSize`.
- MEM/WB latch loads when the stage completes: non-memory op, ack, or ERR. `MEMWBdata` = MemToReg ? load data : ALU result.
- While stalled, the MEM/WB latch loads a bubble (MEMWB_RegWrite=0). No double write-back is permitted.

## Timing
- Reset values: all latches 0, state IDLE, all outputs 0 (`MEM_stall`=0, `dmem_req`=0, `MEM_buserr`=0).
- Non-memory op: EX→EXMEM one cycle, EXMEM→MEMWB one cycle.
- Load/store with ack in the request cycle: the same two cycles, no stall.
- Ack after N wait cycles: N stall cycles.
- A reset asserted mid-ACCESS drops `dmem_req` immediately (asynchronous). The in-flight access is abandoned and must not be replayed.
- An ack arriving in the same cycle the counter reaches `TIMEOUT`: the ack wins.
- A spurious `dmem_ack` in IDLE is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN`:
  - Defined: a word access with addr[1:0]≠0 issues no request. It raises the extra output `MEM_misalign` for one cycle and squashes the instruction.
  - Undefined: the port is absent, and addr[1:0] are ignored for word accesses.

## Structure
- Shared package `pipeline_pkg` holds:
  - `MemSize` encodings (MS_WORD, MS_BYTEU, MS_BYTES);
  - FSM state enum (S_IDLE, S_ACCESS, S_ERR);
  - default `TIMEOUT`.
- One sub-module, `mem_load_align`: combinational lane select and extension of the load data, plus generation of the byte enables and store data.

## Test plan
- ALU op, `EX_ALUOut`=0x1234 → `EXMEMdata`=0x1234 after 1 cycle, `MEMWBdata`=0x1234 after 2 cycles, no stall.
- Word store to addr 0x100, data 0xDEADBEEF, ack held 3 cycles → `MEM_stall` high 3 cycles, `dmem_be`=1111, `dmem_wdata` stable, MEMWB_RegWrite=0.
- Signed byte load from addr 0x103, rdata 0x80000000, immediate ack → `MEMWBdata`=0xFFFFFF80. Unsigned byte load → 0x00000080.
- Ack never arrives (`TIMEOUT`=15) → `MEM_buserr` pulses 1 cycle after 15 wait cycles, stall released, MEMWB_RegWrite=0.
- Reset asserted on the 2nd wait cycle of a load → `dmem_req` and `MEM_stall` drop immediately, all latches 0.
- With `MEM_ALIGN_CHECK_EN` defined, word load from 0x102 → `MEM_misalign` pulse, `dmem_req` stays 0.
